debug_unit: RTL and testbench
=============================

Name: debug_unit

Overview:
- Host-side controller for the pipelined MIPS core; it drives the core's debug and program-load interface.
- Decodes single-byte commands from a UART receiver.
- Streams a program into instruction memory.
- Gates the core's halt line for continuous or single-step execution.
- After a run or step, serializes a snapshot to a UART transmitter: all four pipeline latches, the register file and a window of data memory.

Parameters:
- INST_MEM_WORDS, 256, instruction memory depth in 32-bit words; load address wraps at this depth.
- DUMP_MEM_WORDS, 32, number of data-memory words dumped, starting at byte address 0.
- HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that terminates a program load.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  8  received byte; valid when i_rx_done is high
- i_rx_done  in  1  one-cycle pulse per received byte
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle pulse; starts transmission of o_tx_data
- i_tx_done  in  1  one-cycle pulse when the transmitter is free again
- o_halt  out  1  pipeline freeze; 1 means frozen
- o_write_instruction_flag  out  1  instruction memory write strobe
- o_instruction_to_write  out  32  instruction word to write
- o_address_to_write_inst  out  32  byte address of the instruction write
- i_IF_ID_latch  in  64  IF/ID latch contents
- i_ID_EX_latch  in  139  ID/EX latch contents
- i_EX_MEM_latch  in  76  EX/MEM latch contents
- i_MEM_WB_latch  in  71  MEM/WB latch contents
- o_reg_read  out  5  register file read index
- i_reg_content  in  32  register file read data
- o_address_to_read_from_debug  out  32  data memory read byte address
- i_mem_addr_content_to_debug  in  32  data memory read data
- i_program_end  in  1  core has reached the end of the program

Behaviour:
- Clock and reset: one clock, i_clk. Reset (i_reset) is synchronous and active-high.
- Reset values:
  - state IDLE; o_halt=1
  - o_write_instruction_flag=0, o_tx_start=0
  - all other outputs 0; load pointer 0
- Reset mid-operation: any in-flight load, run or dump is abandoned and no further o_tx_start is issued.
- Commands are accepted only in IDLE; bytes arriving in any other state are dropped.
  - 0x4C 'L': go to LOAD.
  - 0x43 'C': go to RUN.
  - 0x53 'S': go to STEP.
  - any other byte: ignored, stay in IDLE.
- LOAD:
  - Assemble bytes MSB first into a 32-bit word.
  - On the 4th byte, go to LOAD_WR for exactly one cycle: o_write_instruction_flag=1, o_instruction_to_write=word, o_address_to_write_inst=ptr*4. Then increment ptr.
  - Terminate after writing HALT_INSTR, or after writing ptr = INST_MEM_WORDS-1 (ptr then wraps to 0).
  - On termination, send ack 0x4B 'K' and return to IDLE.
  - ptr resets to 0 on each 'L' command.
- RUN:
  - o_halt=0 until i_program_end is sampled high.
  - o_halt=1 on the cycle after that, then go to DUMP.
- STEP:
  - o_halt=0 for exactly one cycle, then o_halt=1, then go to DUMP.
- RUN or STEP with i_program_end already high: o_halt stays 1 and the block goes straight to DUMP.
- DUMP, latch snapshot:
  - On entry, latch a 45-byte snapshot: IF_ID (8 bytes), ID_EX zero-extended to 144 bits (18 bytes), EX_MEM zero-extended to 80 bits (10 bytes), MEM_WB zero-extended to 72 bits (9 bytes).
  - Send the snapshot MSB-first, in that field order.
- DUMP, registers:
  - Then, for r = 0..31: drive o_reg_read=r, wait one cycle, sample i_reg_content, send 4 bytes MSB first.
- DUMP, data memory:
  - Then, for w = 0..DUMP_MEM_WORDS-1: o_address_to_read_from_debug=w*4, wait one cycle, sample, send 4 bytes MSB first.
- DUMP total: 45 + 128 + 4*DUMP_MEM_WORDS bytes (301 at default). Afterwards return to IDLE with o_halt=1.
- TX handshake:
  - o_tx_start pulses for one cycle with o_tx_data stable on that cycle.
  - The next byte is not started until i_tx_done has been seen.
  - o_tx_data holds its value until the next start.
  - i_tx_done outside a wait state is ignored.
- Simultaneous events:
  - i_rx_done during TX wait or DUMP is dropped.
  - i_program_end and a halt release on the same cycle: program end wins.

Decomposition:
- Shared package debug_pkg:
  - command byte constants CMD_LOAD, CMD_CONT, CMD_STEP, ACK_BYTE
  - state enumeration
  - field byte counts (8, 18, 10, 9), snapshot byte count 45, register count 32
- One sub-module: debug_tx_serializer. It takes a byte plus a start request, runs the o_tx_start/i_tx_done handshake and returns a busy/done flag. The main FSM only sequences sources.

Test Plan:
- Load: send 0x4C, then 0x20,0x01,0x00,0x05 and 0xFF×4. Expect a write of 0x20010005 @0x0, then 0xFFFFFFFF @0x4, each with a one-cycle strobe; one TX byte 0x4B; state returns to IDLE.
- Wrap: set INST_MEM_WORDS=4 and load 4 words with no HALT_INSTR. Expect writes @0x0,0x4,0x8,0xC, then ack 0x4B; a 5th word is ignored.
- Step: send 0x53. Expect o_halt low for exactly 1 cycle, then 301 TX bytes. The first 8 bytes equal i_IF_ID_latch as latched on DUMP entry; bytes 45..48 equal R0.
- Continuous: send 0x43 with i_program_end asserted 50 cycles later. Expect o_halt=0 for those 50 cycles, then 1, then a 301-byte dump ending with the memory word @0x7C.
- Robustness: send 0x41 in IDLE, then 0x4C during a dump. Expect no response to either. Assert i_reset mid-dump: the next cycle shows o_halt=1, o_tx_start=0 and state IDLE; a following 'S' dumps normally.
- Back-pressure: delay i_tx_done by 0 to 20 cycles randomly. Expect no byte lost or duplicated and exactly one o_tx_start per byte.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the MIPS debug unit.
package debug_pkg;

    // Host command bytes and the load acknowledge byte
    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] ACK_BYTE = 8'h4B;

    // Raw pipeline latch widths as presented by the core
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 139;
    localparam int EX_MEM_W = 76;
    localparam int MEM_WB_W = 71;

    // Each latch is sent as a whole number of bytes, zero-extended at the top
    localparam int IF_ID_BYTES  = 8;
    localparam int ID_EX_BYTES  = 18;
    localparam int EX_MEM_BYTES = 10;
    localparam int MEM_WB_BYTES = 9;
    localparam int SNAP_BYTES   = IF_ID_BYTES + ID_EX_BYTES + EX_MEM_BYTES + MEM_WB_BYTES;
    localparam int SNAP_W       = SNAP_BYTES * 8;
    localparam int NUM_REGS     = 32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_WR,
        ST_ACK,
        ST_RUN,
        ST_STEP,
        ST_SNAP,
        ST_SNAP_TX,
        ST_REG_WAIT,
        ST_REG_TX,
        ST_MEM_WAIT,
        ST_MEM_TX,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/debug_unit_if.sv
// Debug/program-load bus between the debug unit, the UART and the MIPS core.
interface debug_unit_if;
    import debug_pkg::*;

    logic [7:0]          i_rx_data;
    logic                i_rx_done;
    logic [7:0]          o_tx_data;
    logic                o_tx_start;
    logic                i_tx_done;
    logic                o_halt;
    logic                o_write_instruction_flag;
    logic [31:0]         o_instruction_to_write;
    logic [31:0]         o_address_to_write_inst;
    logic [IF_ID_W-1:0]  i_IF_ID_latch;
    logic [ID_EX_W-1:0]  i_ID_EX_latch;
    logic [EX_MEM_W-1:0] i_EX_MEM_latch;
    logic [MEM_WB_W-1:0] i_MEM_WB_latch;
    logic [4:0]          o_reg_read;
    logic [31:0]         i_reg_content;
    logic [31:0]         o_address_to_read_from_debug;
    logic [31:0]         i_mem_addr_content_to_debug;
    logic                i_program_end;

    // Debug unit side
    modport master (
        input  i_rx_data, i_rx_done, i_tx_done,
        input  i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch, i_MEM_WB_latch,
        input  i_reg_content, i_mem_addr_content_to_debug, i_program_end,
        output o_tx_data, o_tx_start, o_halt,
        output o_write_instruction_flag, o_instruction_to_write, o_address_to_write_inst,
        output o_reg_read, o_address_to_read_from_debug
    );

    // UART and core side
    modport slave (
        output i_rx_data, i_rx_done, i_tx_done,
        output i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch, i_MEM_WB_latch,
        output i_reg_content, i_mem_addr_content_to_debug, i_program_end,
        input  o_tx_data, o_tx_start, o_halt,
        input  o_write_instruction_flag, o_instruction_to_write, o_address_to_write_inst,
        input  o_reg_read, o_address_to_read_from_debug
    );

endinterface

// File: rtl/debug_tx_serializer.sv
// One-byte-at-a-time UART transmit handshake: pulse start, hold data, wait for done.
module debug_tx_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_req,
    input  logic [7:0] start_byte,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy
);

    // Launch a byte when idle; release busy on the transmitter's done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            if (!busy && start_req) begin
                tx_data  <= start_byte;
                tx_start <= 1'b1;
                busy     <= 1'b1;
            end else if (busy && !tx_start && tx_done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/debug_unit.sv
// Host-side debug controller: command decode, program load, run/step gating and state dump.
module debug_unit
    import debug_pkg::*;
#(
    parameter int          INST_MEM_WORDS = 256,
    parameter int          DUMP_MEM_WORDS = 32,
    parameter logic [31:0] HALT_INSTR     = 32'hFFFF_FFFF
) (
    input logic          i_clk,
    input logic          i_reset,
    debug_unit_if.master dbg
);

    localparam logic [31:0] LAST_PTR  = 32'(INST_MEM_WORDS - 1);
    localparam logic [15:0] LAST_REG  = 16'(NUM_REGS - 1);
    localparam logic [15:0] LAST_MEM  = 16'(DUMP_MEM_WORDS - 1);
    localparam logic [5:0]  LAST_SNAP = 6'(SNAP_BYTES - 1);

    state_t      state;
    logic [SNAP_W-1:0] snap;
    logic [5:0]  byte_cnt;
    logic [15:0] idx;
    logic [15:0] idx_n;
    logic [31:0] ptr;
    logic [23:0] load_word;
    logic [1:0]  load_cnt;
    logic        tx_busy;
    logic        send_req;
    logic [7:0]  send_byte;

    // Outgoing bytes always come from the top of the snapshot shifter, except the load ack
    assign send_req  = ((state == ST_ACK) || (state == ST_SNAP_TX) ||
                        (state == ST_REG_TX) || (state == ST_MEM_TX)) && !tx_busy;
    assign send_byte = (state == ST_ACK) ? ACK_BYTE : snap[SNAP_W-1 -: 8];
    assign idx_n     = idx + 16'd1;

    debug_tx_serializer u_tx (
        .clk        (i_clk),
        .rst        (i_reset),
        .start_req  (send_req),
        .start_byte (send_byte),
        .tx_done    (dbg.i_tx_done),
        .tx_data    (dbg.o_tx_data),
        .tx_start   (dbg.o_tx_start),
        .busy       (tx_busy)
    );

    // Main sequencer: decode commands, load program, gate halt, walk the dump sources
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state                            <= ST_IDLE;
            dbg.o_halt                       <= 1'b1;
            dbg.o_write_instruction_flag     <= 1'b0;
            dbg.o_instruction_to_write       <= 32'h0;
            dbg.o_address_to_write_inst      <= 32'h0;
            dbg.o_reg_read                   <= 5'h0;
            dbg.o_address_to_read_from_debug <= 32'h0;
            ptr                              <= 32'h0;
            load_cnt                         <= 2'd0;
            byte_cnt                         <= 6'd0;
            idx                              <= 16'h0;
        end else begin
            dbg.o_write_instruction_flag <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dbg.i_rx_done) begin
                        case (dbg.i_rx_data)
                            CMD_LOAD: begin
                                ptr      <= 32'h0;
                                load_cnt <= 2'd0;
                                state    <= ST_LOAD;
                            end
                            CMD_CONT: begin
                                if (dbg.i_program_end) begin
                                    state <= ST_SNAP;
                                end else begin
                                    dbg.o_halt <= 1'b0;
                                    state      <= ST_RUN;
                                end
                            end
                            CMD_STEP: begin
                                if (dbg.i_program_end) begin
                                    state <= ST_SNAP;
                                end else begin
                                    dbg.o_halt <= 1'b0;
                                    state      <= ST_STEP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (dbg.i_rx_done) begin
                        load_word <= {load_word[15:0], dbg.i_rx_data};
                        load_cnt  <= load_cnt + 2'd1;
                        if (load_cnt == 2'd3) begin
                            dbg.o_write_instruction_flag <= 1'b1;
                            dbg.o_instruction_to_write   <= {load_word, dbg.i_rx_data};
                            dbg.o_address_to_write_inst  <= {ptr[29:0], 2'b00};
                            state                        <= ST_LOAD_WR;
                        end
                    end
                end
                ST_LOAD_WR: begin
                    ptr      <= (ptr == LAST_PTR) ? 32'h0 : ptr + 32'h1;
                    load_cnt <= 2'd0;
                    if ((dbg.o_instruction_to_write == HALT_INSTR) || (ptr == LAST_PTR))
                        state <= ST_ACK;
                    else
                        state <= ST_LOAD;
                end
                ST_ACK: begin
                    if (send_req)
                        state <= ST_FLUSH;
                end
                ST_RUN: begin
                    if (dbg.i_program_end) begin
                        dbg.o_halt <= 1'b1;
                        state      <= ST_SNAP;
                    end
                end
                ST_STEP: begin
                    dbg.o_halt <= 1'b1;
                    state      <= ST_SNAP;
                end
                ST_SNAP: begin
                    snap <= {dbg.i_IF_ID_latch,
                             {(ID_EX_BYTES*8 - ID_EX_W){1'b0}},   dbg.i_ID_EX_latch,
                             {(EX_MEM_BYTES*8 - EX_MEM_W){1'b0}}, dbg.i_EX_MEM_latch,
                             {(MEM_WB_BYTES*8 - MEM_WB_W){1'b0}}, dbg.i_MEM_WB_latch};
                    byte_cnt <= 6'd0;
                    state    <= ST_SNAP_TX;
                end
                ST_SNAP_TX: begin
                    if (send_req) begin
                        snap     <= {snap[SNAP_W-9:0], 8'h00};
                        byte_cnt <= byte_cnt + 6'd1;
                        if (byte_cnt == LAST_SNAP) begin
                            idx            <= 16'h0;
                            dbg.o_reg_read <= 5'h0;
                            state          <= ST_REG_WAIT;
                        end
                    end
                end
                ST_REG_WAIT: begin
                    snap[SNAP_W-1 -: 32] <= dbg.i_reg_content;
                    byte_cnt             <= 6'd0;
                    state                <= ST_REG_TX;
                end
                ST_REG_TX: begin
                    if (send_req) begin
                        snap     <= {snap[SNAP_W-9:0], 8'h00};
                        byte_cnt <= byte_cnt + 6'd1;
                        if (byte_cnt == 6'd3) begin
                            if (idx == LAST_REG) begin
                                idx                              <= 16'h0;
                                dbg.o_address_to_read_from_debug <= 32'h0;
                                state                            <= ST_MEM_WAIT;
                            end else begin
                                idx            <= idx_n;
                                dbg.o_reg_read <= idx_n[4:0];
                                state          <= ST_REG_WAIT;
                            end
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    snap[SNAP_W-1 -: 32] <= dbg.i_mem_addr_content_to_debug;
                    byte_cnt             <= 6'd0;
                    state                <= ST_MEM_TX;
                end
                ST_MEM_TX: begin
                    if (send_req) begin
                        snap     <= {snap[SNAP_W-9:0], 8'h00};
                        byte_cnt <= byte_cnt + 6'd1;
                        if (byte_cnt == 6'd3) begin
                            if (idx == LAST_MEM) begin
                                state <= ST_FLUSH;
                            end else begin
                                idx                              <= idx_n;
                                dbg.o_address_to_read_from_debug <= {14'h0, idx_n, 2'b00};
                                state                            <= ST_MEM_WAIT;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!tx_busy)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: queued expected TX bytes and instruction writes.
module tb_debug_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   halt_low;
    logic [7:0]  exp_q[$];
    logic [63:0] wr_q[$];

    logic [63:0]  if_id_v;
    logic [138:0] id_ex_v;
    logic [75:0]  ex_mem_v;
    logic [70:0]  mem_wb_v;

    debug_unit_if dif();

    debug_unit #(
        .INST_MEM_WORDS (4),
        .DUMP_MEM_WORDS (32),
        .HALT_INSTR     (32'hFFFF_FFFF)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .dbg     (dif)
    );

    function automatic logic [31:0] reg_word(input int r);
        return 32'(32'h1111_1111 * (r + 1));
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hD000_0000 | addr;
    endfunction

    // Register file and data memory models (combinational read)
    always_comb begin
        dif.i_reg_content               = reg_word(int'(dif.o_reg_read));
        dif.i_mem_addr_content_to_debug = mem_word(dif.o_address_to_read_from_debug);
    end

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #900_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic push_dump();
        logic [359:0] s;
        s = {if_id_v, 5'b0, id_ex_v, 4'b0, ex_mem_v, 1'b0, mem_wb_v};
        for (int i = 0; i < 45; i++) exp_q.push_back(s[359 - 8*i -: 8]);
        for (int r = 0; r < 32; r++) push_word(reg_word(r));
        for (int w = 0; w < 32; w++) push_word(mem_word(32'(w * 4)));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        dif.i_rx_data = b;
        dif.i_rx_done = 1'b1;
        @(negedge clk);
        dif.i_rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && c < 10000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c >= 10000) begin
            errors++;
            $display("FAIL %s: timeout, %0d bytes and %0d writes outstanding, required 0",
                     name, exp_q.size(), wr_q.size());
            exp_q.delete();
            wr_q.delete();
        end
        repeat (30) @(negedge clk);
    endtask

    task automatic wait_below(input int n);
        int g;
        g = 0;
        while (exp_q.size() >= n && g < 10000) begin
            @(negedge clk);
            g++;
        end
    endtask

    // Monitor: transmitter model with random done latency, TX and write scoreboards, halt counter
    initial begin
        bit         pend;
        bit         was_pend;
        int         dcnt;
        logic [7:0] eb;
        logic [63:0] ew;
        pend = 0;
        dcnt = 0;
        dif.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
                dif.i_tx_done = 1'b0;
            end else begin
                if (!dif.o_halt) halt_low++;
                was_pend = pend;
                dif.i_tx_done = 1'b0;
                if (pend) begin
                    if (dcnt == 0) begin
                        dif.i_tx_done = 1'b1;
                        pend = 0;
                    end else begin
                        dcnt--;
                    end
                end
                if (dif.o_tx_start) begin
                    checks++;
                    if (was_pend) begin
                        errors++;
                        $display("FAIL tx_overlap: start while byte pending, got 1 required 0");
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL tx_unexpected: got byte %h, required no byte", dif.o_tx_data);
                    end else begin
                        eb = exp_q.pop_front();
                        if (dif.o_tx_data !== eb) begin
                            errors++;
                            $display("FAIL tx_byte (%0d left): got %h, required %h",
                                     exp_q.size(), dif.o_tx_data, eb);
                        end
                    end
                    pend = 1;
                    dcnt = $urandom_range(0, 20);
                end
                if (dif.o_write_instruction_flag) begin
                    checks++;
                    if (wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL wr_unexpected: got %h @%h, required no write",
                                 dif.o_instruction_to_write, dif.o_address_to_write_inst);
                    end else begin
                        ew = wr_q.pop_front();
                        if ({dif.o_address_to_write_inst, dif.o_instruction_to_write} !== ew) begin
                            errors++;
                            $display("FAIL wr_word: got %h @%h, required %h @%h",
                                     dif.o_instruction_to_write, dif.o_address_to_write_inst,
                                     ew[31:0], ew[63:32]);
                        end
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int n;
        int g;
        checks   = 0;
        errors   = 0;
        halt_low = 0;
        if_id_v  = 64'h0123_4567_89AB_CDEF;
        id_ex_v  = {11'h5A5, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF};
        ex_mem_v = {12'hABC, 64'hFEDC_BA98_7654_3210};
        mem_wb_v = {7'h55, 64'h0F1E_2D3C_4B5A_6978};
        dif.i_rx_data      = 8'h00;
        dif.i_rx_done      = 1'b0;
        dif.i_program_end  = 1'b0;
        dif.i_IF_ID_latch  = if_id_v;
        dif.i_ID_EX_latch  = id_ex_v;
        dif.i_EX_MEM_latch = ex_mem_v;
        dif.i_MEM_WB_latch = mem_wb_v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values
        check_val("rst_halt",    32'(dif.o_halt), 32'h1);
        check_val("rst_wflag",   32'(dif.o_write_instruction_flag), 32'h0);
        check_val("rst_txstart", 32'(dif.o_tx_start), 32'h0);
        check_val("rst_txdata",  32'(dif.o_tx_data), 32'h0);
        check_val("rst_instr",   dif.o_instruction_to_write, 32'h0);
        check_val("rst_iaddr",   dif.o_address_to_write_inst, 32'h0);
        check_val("rst_regrd",   32'(dif.o_reg_read), 32'h0);
        check_val("rst_maddr",   dif.o_address_to_read_from_debug, 32'h0);

        // Load terminated by the halt instruction
        wr_q.push_back({32'h0, 32'h2001_0005});
        wr_q.push_back({32'h4, 32'hFFFF_FFFF});
        exp_q.push_back(8'h4B);
        send_byte(8'h4C);
        repeat (2) @(negedge clk);
        send_word(32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        wait_drain("load_halt");
        check_val("load_halt_after", 32'(dif.o_halt), 32'h1);

        // Load wrapping at depth 4, then a fifth word arriving in IDLE is ignored
        wr_q.push_back({32'h0, 32'h0102_0304});
        wr_q.push_back({32'h4, 32'h0A0B_0C0D});
        wr_q.push_back({32'h8, 32'h1112_1314});
        wr_q.push_back({32'hC, 32'h2122_2324});
        exp_q.push_back(8'h4B);
        send_byte(8'h4C);
        repeat (2) @(negedge clk);
        send_word(32'h0102_0304);
        send_word(32'h0A0B_0C0D);
        send_word(32'h1112_1314);
        send_word(32'h2122_2324);
        wait_drain("load_wrap");
        send_word(32'h1122_3344);
        repeat (40) @(negedge clk);

        // Unknown command is ignored
        send_byte(8'h41);
        repeat (40) @(negedge clk);

        // Single step; latch inputs change after the snapshot is taken
        halt_low = 0;
        push_dump();
        send_byte(8'h53);
        wait_below(301);
        dif.i_IF_ID_latch  = ~if_id_v;
        dif.i_ID_EX_latch  = ~id_ex_v;
        dif.i_EX_MEM_latch = ~ex_mem_v;
        dif.i_MEM_WB_latch = ~mem_wb_v;
        wait_drain("step_dump");
        check_val("step_halt_low", 32'(halt_low), 32'd1);
        dif.i_IF_ID_latch  = if_id_v;
        dif.i_ID_EX_latch  = id_ex_v;
        dif.i_EX_MEM_latch = ex_mem_v;
        dif.i_MEM_WB_latch = mem_wb_v;

        // Continuous run, program end after 50 running cycles
        halt_low = 0;
        push_dump();
        send_byte(8'h43);
        n = (dif.o_halt == 1'b0) ? 1 : 0;
        g = 0;
        while (n < 50 && g < 200) begin
            @(negedge clk);
            g++;
            if (dif.o_halt == 1'b0) n++;
        end
        dif.i_program_end = 1'b1;
        wait_drain("run_dump");
        check_val("run_halt_low", 32'(halt_low), 32'd50);
        dif.i_program_end = 1'b0;

        // Step with program already ended: no release, straight to dump
        dif.i_program_end = 1'b1;
        halt_low = 0;
        push_dump();
        send_byte(8'h53);
        wait_drain("ended_dump");
        check_val("ended_halt_low", 32'(halt_low), 32'd0);
        dif.i_program_end = 1'b0;

        // A load command arriving mid-dump is dropped
        push_dump();
        send_byte(8'h53);
        wait_below(250);
        send_byte(8'h4C);
        wait_drain("drop_dump");

        // Reset mid-dump abandons the dump
        push_dump();
        send_byte(8'h53);
        wait_below(200);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_halt",    32'(dif.o_halt), 32'h1);
        check_val("midrst_txstart", 32'(dif.o_tx_start), 32'h0);
        repeat (40) @(negedge clk);

        // Normal dump after the mid-dump reset
        halt_low = 0;
        push_dump();
        send_byte(8'h53);
        wait_drain("post_rst_dump");
        check_val("post_rst_halt_low", 32'(halt_low), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
